// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_ctrl                                                 |
// | Description : UART transmit framer (start, LSB-first data, optional parity,|
// |               1-2 stop bits) paced by an external baud tick, with abort.   |
// |               Optional parity bit enabled by defining UART_PARITY_EN.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 tx_abort,
  input  logic                 baud_tick,
  output logic                 baud_en,
  output logic                 txd,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CW = $clog2(DATA_BITS + 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] c_PARITY = 3'd3;
`endif
  localparam logic [2:0] c_STOP   = 3'd4;

  localparam logic [CW-1:0] c_DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] c_STOP_LAST = CW'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_ctrl: parameter out of legal range");
  end

  logic [2:0]           r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [CW-1:0]        r_bit_cnt;
  logic [CW-1:0]        r_stop_cnt;
  logic                 r_txd;
  logic                 r_tx_ready;
  logic                 r_baud_en;
  logic                 r_busy;
  logic                 r_frame_done;
`ifdef UART_PARITY_EN
  logic                 r_parity;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= '0;
      r_txd        <= 1'b1;
      r_tx_ready   <= 1'b1;
      r_baud_en    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef UART_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      if (r_state == c_IDLE) begin
        // baud_tick and tx_abort carry no meaning here; only an accept moves us
        if (tx_valid) begin
          r_state    <= c_START;
          r_shift    <= tx_data;
          r_bit_cnt  <= '0;
          r_stop_cnt <= '0;
          r_txd      <= 1'b0;
          r_tx_ready <= 1'b0;
          r_baud_en  <= 1'b1;
          r_busy     <= 1'b1;
`ifdef UART_PARITY_EN
          r_parity   <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
        end
      end else if (tx_abort) begin
        r_state    <= c_IDLE;
        r_txd      <= 1'b1;
        r_tx_ready <= 1'b1;
        r_baud_en  <= 1'b0;
        r_busy     <= 1'b0;
      end else if (baud_tick) begin
        case (r_state)
          c_START: begin
            r_state <= c_DATA;
            r_txd   <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
          c_DATA: begin
            if (r_bit_cnt == c_DATA_LAST) begin
`ifdef UART_PARITY_EN
              r_state <= c_PARITY;
              r_txd   <= r_parity;
`else
              r_state <= c_STOP;
              r_txd   <= 1'b1;
`endif
            end else begin
              r_txd     <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + CW'(1);
            end
          end
`ifdef UART_PARITY_EN
          c_PARITY: begin
            r_state <= c_STOP;
            r_txd   <= 1'b1;
          end
`endif
          c_STOP: begin
            if (r_stop_cnt == c_STOP_LAST) begin
              r_state      <= c_IDLE;
              r_frame_done <= 1'b1;
              r_tx_ready   <= 1'b1;
              r_baud_en    <= 1'b0;
              r_busy       <= 1'b0;
            end else begin
              r_stop_cnt <= r_stop_cnt + CW'(1);
            end
          end
          default: begin
            r_state    <= c_IDLE;
            r_txd      <= 1'b1;
            r_tx_ready <= 1'b1;
            r_baud_en  <= 1'b0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign txd        = r_txd;
  assign tx_ready   = r_tx_ready;
  assign baud_en    = r_baud_en;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_ctrl                                              |
// | Description : Randomised scoreboard bench for uart_tx_ctrl; frame model is |
// |               a bit list derived from the byte; honours UART_PARITY_EN.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_tx_ctrl;

  localparam int DB   = 8;
  localparam int SB   = 2;
  localparam int PODD = 0;
  localparam int TICK = 8;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB   = 1 + DB + PB + SB;
  localparam int FLEN = NB * TICK;
  localparam int NF   = 40;

  localparam int K_NORMAL = 0;
  localparam int K_ABORT  = 1;
  localparam int K_RESET  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DB-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_abort;
  logic          baud_tick;
  logic          baud_en;
  logic          txd;
  logic          busy;
  logic          frame_done;

  uart_tx_ctrl #(
    .DATA_BITS  (DB),
    .STOP_BITS  (SB),
    .PARITY_ODD (PODD)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_abort   (tx_abort),
    .baud_tick  (baud_tick),
    .baud_en    (baud_en),
    .txd        (txd),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DB-1:0] data;
    int            cut;
    bit            b2b;
  } frame_t;

  frame_t        exp_q[$];
  int            checks = 0;
  int            passed = 0;

  logic [DB-1:0] pd [NF];
  int            pk [NF];
  int            pc [NF];
  bit            pb [NF];
  int            pg [NF];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
  endtask

  // Line level for bit slot k of a frame carrying d
  function automatic logic frame_bit(input logic [DB-1:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= DB) return d[k-1];
    if (PB == 1 && k == DB + 1) return (^d) ^ (PODD != 0);
    return 1'b1;
  endfunction

  // Baud generator model: phase held at zero while disabled; stray ticks while idle
  int div;
  initial begin
    div       = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (baud_en) begin
        baud_tick = (div == TICK - 1);
        div       = (div == TICK - 1) ? 0 : div + 1;
      end else begin
        div       = 0;
        baud_tick = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: frames are recognised by busy rising and checked cycle by cycle
  frame_t cur;
  bit     mon_active = 1'b0;
  int     mon_n      = 0;
  int     mon_cyc    = 0;
  int     last_done  = -100;

  initial begin
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (!mon_active) begin
        if (busy) begin
          check("frame_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            cur        = exp_q.pop_front();
            mon_active = 1'b1;
            mon_n      = 1;
            if (cur.b2b) check("b2b_gap", 32'(mon_cyc - last_done), 1);
          end
        end else begin
          check("idle_outputs", {txd, busy, tx_ready, baud_en, frame_done}, 5'b10100);
        end
      end
      if (mon_active) begin
        if (cur.cut != 0 && mon_n == cur.cut + 1) begin
          check("cut_outputs", {txd, busy, tx_ready, baud_en, frame_done}, 5'b10100);
          mon_active = 1'b0;
        end else if (mon_n == FLEN + 1) begin
          check("frame_done", {txd, busy, tx_ready, baud_en, frame_done}, 5'b10101);
          last_done  = mon_cyc;
          mon_active = 1'b0;
        end else begin
          check("txd_bit", 32'(txd), 32'(frame_bit(cur.data, (mon_n - 1) / TICK)));
          check("busy_ctrl", {busy, tx_ready, baud_en, frame_done}, 4'b1010);
        end
        mon_n++;
      end
    end
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", passed, checks);
    $fatal(1);
  end

  // Driver
  int     n;
  int     gap;
  bit     stop_run;
  bit     prev_normal;
  frame_t rec;

  initial begin
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_abort = 1'b0;
    tx_data  = '0;
    stop_run = 1'b0;

    for (int f = 0; f < NF; f++) begin
      int r;
      r     = $urandom_range(0, 9);
      pd[f] = DB'($urandom);
      pk[f] = (r < 2) ? K_ABORT : (r == 2) ? K_RESET : K_NORMAL;
      pc[f] = $urandom_range(1, FLEN);
      pb[f] = ($urandom_range(0, 2) == 0);
      pg[f] = $urandom_range(0, 3);
    end
    pd[0] = 8'hA5; pk[0] = K_NORMAL; pb[0] = 1'b0; pg[0] = 1;
    pd[1] = 8'h07; pk[1] = K_NORMAL; pb[1] = 1'b0; pg[1] = 0;
    pd[2] = 8'h00; pk[2] = K_NORMAL; pb[2] = 1'b1; pg[2] = 2;
    pd[3] = 8'hFF; pk[3] = K_NORMAL; pb[3] = 1'b0;
    pd[4] = 8'h3C; pk[4] = K_ABORT;  pb[4] = 1'b0; pc[4] = 4 * TICK + 3;
    pd[5] = 8'h55; pk[5] = K_NORMAL; pb[5] = 1'b0; pg[5] = 1;
    pd[6] = 8'hC3; pk[6] = K_RESET;  pb[6] = 1'b0; pc[6] = (1 + DB + PB) * TICK + 5;
    pd[7] = 8'h5A; pk[7] = K_ABORT;  pb[7] = 1'b1; pc[7] = FLEN;
    pd[8] = 8'h96; pk[8] = K_NORMAL; pb[8] = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_values", {txd, busy, tx_ready, baud_en, frame_done}, 5'b10100);
    rst_n       = 1'b1;
    prev_normal = 1'b0;

    for (int f = 0; f < NF; f++) begin
      if (stop_run) break;
      gap = 0;
      if (!(f > 0 && pb[f-1] && prev_normal)) begin
        tx_valid = 1'b0;
        gap      = pg[f];
        repeat (gap) @(negedge clk);
      end
      tx_data  = pd[f];
      tx_valid = 1'b1;
      // abort alongside valid while idle must not block the accept
      tx_abort = (f == 1) || ($urandom_range(0, 3) == 0);
      n = 0;
      while (!tx_ready) begin
        @(negedge clk);
        n++;
        if (n > 4 * FLEN) begin
          check("ready_timeout", 32'(n), 32'(4 * FLEN));
          stop_run = 1'b1;
          break;
        end
      end
      if (stop_run) break;

      rec.data = pd[f];
      rec.cut  = (pk[f] == K_NORMAL) ? 0 : pc[f];
      rec.b2b  = (f > 0) && (gap == 0) && prev_normal;
      exp_q.push_back(rec);

      n = 0;
      do begin
        @(negedge clk);
        n++;
        tx_abort = (pk[f] == K_ABORT) && (n == pc[f]);
        if (pb[f] && f + 1 < NF) begin
          tx_data = pd[f+1];
        end else begin
          tx_valid = 1'b0;
          tx_data  = DB'($urandom);
        end
        if (pk[f] == K_RESET && n == pc[f]) begin
          #2 rst_n = 1'b0;
          tx_valid = 1'b0;
          #1 check("async_reset", {txd, busy, tx_ready, baud_en, frame_done}, 5'b10100);
          @(negedge clk);
          @(negedge clk);
          rst_n = 1'b1;
        end
        if (n > FLEN + 10) begin
          check("frame_timeout", 32'(n), 32'(FLEN));
          stop_run = 1'b1;
          break;
        end
      end while (!tx_ready);
      prev_normal = (pk[f] == K_NORMAL);
    end

    tx_valid = 1'b0;
    tx_abort = 1'b0;
    repeat (2 * TICK) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    check("monitor_idle", 32'(mon_active), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
